// File: rtl/layer_input_buffer.sv
// -----------------------------------------------------------------------------
// layer_input_buffer
//
// Holds the input vector of one neural-network layer. Words arrive serially
// and shift into the slot array (FILL). Once every slot is loaded the set is
// presented in parallel on neuron_inputs (FULL). From FULL the slots can be
// reloaded in one cycle from the neuron outputs (feedback to the next layer),
// or read out serially, highest slot first, over a valid/ready port (DRAIN).
//
// Optional feature:
//   LAYER_INPUT_BUFFER_RELU_EN - when defined, feedback_load clamps negative
//                                (MSB=1) neuron outputs to zero.
//
// Parameters:
//   WIDTH          - bits per slot / data word
//   NUM_INPUTS     - number of slots (2..16)
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rstn           - synchronous active-low reset
//   clear          - synchronous flush back to FILL with zeroed slots
//   in_valid       - in_data qualifier
//   in_data        - serial input word
//   in_ready       - high while filling
//   neuron_outputs - parallel neuron results, neuron k at [k*WIDTH +: WIDTH]
//   feedback_load  - pulse: load neuron_outputs into the slots (FULL only)
//   drain_start    - pulse: start serial readout (FULL only)
//   neuron_inputs  - slot k at [k*WIDTH +: WIDTH]
//   inputs_valid   - high while a complete input set is held (FULL)
//   out_valid      - out_data qualifier (DRAIN only)
//   out_data       - slot currently being drained, 0 outside DRAIN
//   out_ready      - consumer accepts out_data
// -----------------------------------------------------------------------------
module layer_input_buffer #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] neuron_outputs,
  input  logic                        feedback_load,
  input  logic                        drain_start,
  output logic [NUM_INPUTS*WIDTH-1:0] neuron_inputs,
  output logic                        inputs_valid,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int IDX_W = $clog2(NUM_INPUTS);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_FULL,
    ST_DRAIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] fill_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic [WIDTH-1:0] slots [NUM_INPUTS];

  // Word stored by feedback_load.
  function automatic logic [WIDTH-1:0] fb_word(input logic [WIDTH-1:0] w);
`ifdef LAYER_INPUT_BUFFER_RELU_EN
    return w[WIDTH-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // Clear shares the reset path: both return to an empty FILL with zero slots.
  always_ff @(posedge clk) begin
    // NOTE: slots are a handful of registers, not a RAM, so they can be reset;
    // zeroed slots on reset/clear are observable on neuron_inputs.
    if (!rstn || clear) begin
      // NOTE: non-blocking assignments everywhere in sequential logic so every
      // slot shifts from its pre-edge neighbour value.
      state    <= ST_FILL;
      fill_cnt <= '0;
      rd_idx   <= '0;
      for (int k = 0; k < NUM_INPUTS; k++) slots[k] <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (in_valid) begin
            slots[0] <= in_data;
            for (int k = 1; k < NUM_INPUTS; k++) slots[k] <= slots[k-1];
            if (fill_cnt == CNT_W'(NUM_INPUTS - 1)) begin
              state    <= ST_FULL;
              fill_cnt <= CNT_W'(NUM_INPUTS);
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        ST_FULL: begin
          // Feedback wins over a simultaneous drain request.
          if (feedback_load) begin
            for (int k = 0; k < NUM_INPUTS; k++)
              slots[k] <= fb_word(neuron_outputs[k*WIDTH +: WIDTH]);
          end else if (drain_start) begin
            state  <= ST_DRAIN;
            rd_idx <= IDX_W'(NUM_INPUTS - 1);
          end
        end
        ST_DRAIN: begin
          // Slots are left intact; a following fill overwrites them by shifting.
          if (out_ready) begin
            if (rd_idx == '0) begin
              state    <= ST_FILL;
              fill_cnt <= '0;
            end else begin
              rd_idx <= rd_idx - 1'b1;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign in_ready     = (state == ST_FILL);
  assign inputs_valid = (state == ST_FULL);
  assign out_valid    = (state == ST_DRAIN);
  assign out_data     = (state == ST_DRAIN) ? slots[rd_idx] : '0;

  always_comb begin
    // NOTE: default assignment first so no bit is left unassigned (no latch).
    neuron_inputs = '0;
    for (int k = 0; k < NUM_INPUTS; k++)
      neuron_inputs[k*WIDTH +: WIDTH] = slots[k];
  end

endmodule

// File: doc/layer_input_buffer.md
LAYER_INPUT_BUFFER -- requirements
Module: layer_input_buffer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of every data slot, input word and output word.
REQ-002 Parameter NUM_INPUTS, default 4, range 2..16, SHALL set the number of neuron input slots.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rstn, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port clear, input, 1, SHALL request a synchronous flush to FILL when high.
REQ-006 Port in_valid, input, 1, SHALL mark in_data as valid.
REQ-007 Port in_data, input, WIDTH, SHALL carry a new network input word.
REQ-008 Port in_ready, output, 1, SHALL be high when the block accepts in_data.
REQ-009 Port neuron_outputs, input, NUM_INPUTS*WIDTH, SHALL carry the neuron outputs; neuron k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port feedback_load, input, 1, SHALL be a one-cycle pulse that captures neuron_outputs as the next layer's inputs.
REQ-011 Port drain_start, input, 1, SHALL be a one-cycle pulse that starts serial readout of the slots.
REQ-012 Port neuron_inputs, output, NUM_INPUTS*WIDTH, SHALL expose slot k at bits [k*WIDTH +: WIDTH].
REQ-013 Port inputs_valid, output, 1, SHALL be high while all slots hold a complete input set.
REQ-014 Port out_valid, output, 1, SHALL mark out_data as valid.
REQ-015 Port out_data, output, WIDTH, SHALL carry the slot being drained.
REQ-016 Port out_ready, input, 1, SHALL be the consumer's acceptance of out_data.

Function
REQ-017 The block SHALL have three states: FILL, FULL, DRAIN; a fill counter in 0..NUM_INPUTS; and a read index in 0..NUM_INPUTS-1.
REQ-018 In FILL, in_ready SHALL be 1; on in_valid&&in_ready, slot0<=in_data, slot k<=slot k-1 for k>=1, and the fill counter SHALL increment.
REQ-019 On the accept that brings the fill counter to NUM_INPUTS, the next state SHALL be FULL; inputs_valid SHALL be 1 from the following cycle.
REQ-020 In FULL, in_ready SHALL be 0 and in_valid SHALL be ignored; slots SHALL hold.
REQ-021 In FULL, feedback_load SHALL load slot k<=neuron_outputs[k] for all k in one cycle; the state SHALL remain FULL.
REQ-022 In FULL, drain_start SHALL move to DRAIN with read index NUM_INPUTS-1.
REQ-023 If feedback_load and drain_start are high in the same FULL cycle, the feedback SHALL be applied and drain_start SHALL be ignored.
REQ-024 In FILL and DRAIN, feedback_load and drain_start SHALL be ignored.
REQ-025 In DRAIN, out_valid SHALL be 1, out_data SHALL equal slot[read index], and out_data SHALL be stable until out_valid&&out_ready.
REQ-026 On each out_valid&&out_ready in DRAIN, the read index SHALL decrement; the handshake at index 0 SHALL move to FILL with the fill counter at 0.
REQ-027 Outside DRAIN, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-028 Slot contents SHALL persist from DRAIN into FILL until they are overwritten by shifting.
REQ-029 clear SHALL have priority over all other inputs: next state FILL, fill counter 0, read index 0, all slots 0.

Reset
REQ-030 While rstn=0 at a rising clk edge, the block SHALL enter the state given by the following values.
REQ-031 State SHALL be FILL, and the fill counter and read index SHALL be 0.
REQ-032 All slots and neuron_inputs SHALL be 0.
REQ-033 inputs_valid and out_valid SHALL be 0, out_data SHALL be 0, and in_ready SHALL be 1 from the first cycle after reset.
REQ-034 Reset asserted during DRAIN or FULL SHALL abort the operation with no further out_valid.

Configuration
REQ-035 With macro LAYER_INPUT_BUFFER_RELU_EN defined, feedback_load SHALL treat each neuron_outputs word as two's-complement and store 0 for negative values (MSB=1).
REQ-036 Without LAYER_INPUT_BUFFER_RELU_EN, feedback_load SHALL store neuron_outputs words unmodified.

Verification
REQ-037 Default parameters; accept in_data 0x11,0x22,0x33,0x44 -> neuron_inputs slots 0..3 = 0x44,0x33,0x22,0x11; inputs_valid=1 on the cycle after the 4th accept; in_ready=0.
REQ-038 While FULL, pulse feedback_load with neuron_outputs {0x81,0x05,0x7F,0x00} (slots 3..0) -> slots 3..0 = 0x81,0x05,0x7F,0x00; with RELU_EN, slots 3..0 = 0x00,0x05,0x7F,0x00.
REQ-039 After drain_start, hold out_ready=0 for 3 cycles then 1 -> out_data is held at slot3 while stalled, then the sequence is slot3,slot2,slot1,slot0; the block is back in FILL with in_ready=1.
REQ-040 Drive feedback_load and drain_start together in FULL -> the slots update and out_valid stays 0.
REQ-041 Assert clear after 2 accepts, then assert rstn=0 mid-DRAIN -> all slots are 0 and FILL is entered each time; 4 further accepts are needed before inputs_valid is set.
REQ-042 With NUM_INPUTS=8 and WIDTH=12, accept 8 words 0x001..0x008 -> slot0=0x008 and slot7=0x001; the drain returns 0x001 first and 0x008 last.
